frame_scanout: RTL

Raster scan-out engine for the display adapter: the read-side counterpart of the buffer-to-frame write path. It walks the frame memory in raster order, issuing 16-bit read addresses and emitting 8-bit pixels framed by horizontal/vertical blanking flags. The blanking and active-size programming inputs are the same VB/HB/AIP/AIL values that the write path uses. It sits between the frame memory read port and the panel-side pixel interface.

---
 rtl/display_pkg.sv | 18 +
 rtl/frame_scanout_if.sv | 35 +++
 rtl/frame_scanout_raster_counter.sv | 77 +++++++
 rtl/frame_scanout.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared display-adapter widths and the scan-out FSM state encoding.
package display_pkg;

  localparam int DIM_W  = 10;
  localparam int ADDR_W = 16;
  localparam int PIX_W  = 8;

  // Line length (AIP+HB) and frame height (AIL+VB) need one extra bit.
  localparam int LEN_W  = DIM_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } scanout_state_t;

endpackage

// File: rtl/frame_scanout_if.sv
// Frame memory read port plus panel-side pixel stream of the scan-out engine.
interface frame_scanout_if;

  logic                            FrameREn;
  logic [display_pkg::ADDR_W-1:0]  FrameRAddr;
  logic [display_pkg::PIX_W-1:0]   FrameRData;
  logic [display_pkg::PIX_W-1:0]   PixelOut;
  logic                            PixelValid;
  logic                            HBlank;
  logic                            VBlank;
  logic                            FrameStart;

  modport master (
    output FrameREn,
    output FrameRAddr,
    input  FrameRData,
    output PixelOut,
    output PixelValid,
    output HBlank,
    output VBlank,
    output FrameStart
  );

  modport slave (
    input  FrameREn,
    input  FrameRAddr,
    output FrameRData,
    input  PixelOut,
    input  PixelValid,
    input  HBlank,
    input  VBlank,
    input  FrameStart
  );

endinterface

// File: rtl/frame_scanout_raster_counter.sv
// Raster position counters and frame-latched geometry for the scan-out engine.
module raster_counter
  import display_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [DIM_W-1:0] vb_i,
  input  logic [DIM_W-1:0] hb_i,
  input  logic [DIM_W-1:0] aip_i,
  input  logic [DIM_W-1:0] ail_i,
  output logic             first_o,
  output logic             act_end_o,
  output logic             hb_pos_o,
  output logic             last_line_o,
  output logic             eol_o,
  output logic             eof_o
);

  logic [DIM_W-1:0] vb_q;
  logic [DIM_W-1:0] hb_q;
  logic [DIM_W-1:0] aip_q;
  logic [DIM_W-1:0] ail_q;
  logic [LEN_W-1:0] hcnt_q, hcnt_d;
  logic [LEN_W-1:0] vcnt_q, vcnt_d;
  logic [LEN_W-1:0] line_len;
  logic [LEN_W-1:0] frame_lines;

  assign line_len    = {1'b0, aip_q} + {1'b0, hb_q};
  assign frame_lines = {1'b0, ail_q} + {1'b0, vb_q};

  assign first_o     = (hcnt_q == '0) && (vcnt_q == '0);
  assign act_end_o   = (hcnt_q == {1'b0, aip_q} - LEN_W'(1));
  assign hb_pos_o    = (hcnt_q >= {1'b0, aip_q});
  assign last_line_o = (vcnt_q == {1'b0, ail_q} - LEN_W'(1));
  assign eol_o       = (hcnt_q == line_len - LEN_W'(1));
  // vcnt keeps counting through the vertical blank lines.
  assign eof_o       = eol_o && (vcnt_q == frame_lines - LEN_W'(1));

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (load_i) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (adv_i) begin
      if (eol_o) begin
        hcnt_d = '0;
        vcnt_d = vcnt_q + LEN_W'(1);
      end else begin
        hcnt_d = hcnt_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      vb_q   <= '0;
      hb_q   <= '0;
      aip_q  <= '0;
      ail_q  <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      if (load_i) begin
        vb_q  <= vb_i;
        hb_q  <= hb_i;
        aip_q <= aip_i;
        ail_q <= ail_i;
      end
    end
  end

endmodule

// File: rtl/frame_scanout.sv
// Raster scan-out engine: reads frame memory in raster order and emits blanked pixels.
// Optional FRAME_SCANOUT_CHECKSUM_EN adds a per-frame pixel checksum.
//
// state  | meaning
// IDLE   | waiting for CSDisplay with non-zero active size
// ACTIVE | issuing one frame memory read per cycle
// HBLANK | horizontal blank after an active line
// VBLANK | whole blank lines after the last active line
module frame_scanout
  import display_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              CSDisplay,
  input  logic [DIM_W-1:0]  VBOut_PD,
  input  logic [DIM_W-1:0]  HBOut_PD,
  input  logic [DIM_W-1:0]  AIPOut_PD,
  input  logic [DIM_W-1:0]  AILOut_PD,
`ifdef FRAME_SCANOUT_CHECKSUM_EN
  output logic [15:0]       FrameChecksum,
  output logic              ChecksumValid,
`endif
  frame_scanout_if.master   bus
);

  scanout_state_t    state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ren_q;
  logic              valid_q;
  logic              hblank_q;
  logic              vblank_q;
  logic              fstart_q;

  logic start_ok;
  logic load;
  logic adv;
  logic line_end;
  logic boundary;
  logic first;
  logic act_end;
  logic hb_pos;
  logic last_line;
  logic eol;
  logic eof;

  assign start_ok = CSDisplay && (AIPOut_PD != '0) && (AILOut_PD != '0);

  raster_counter u_raster (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load),
    .adv_i       (adv),
    .vb_i        (VBOut_PD),
    .hb_i        (HBOut_PD),
    .aip_i       (AIPOut_PD),
    .ail_i       (AILOut_PD),
    .first_o     (first),
    .act_end_o   (act_end),
    .hb_pos_o    (hb_pos),
    .last_line_o (last_line),
    .eol_o       (eol),
    .eof_o       (eof)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    load     = 1'b0;
    adv      = 1'b0;
    line_end = 1'b0;
    boundary = 1'b0;

    unique case (state_q)
      IDLE: boundary = 1'b1;
      ACTIVE: begin
        adv    = 1'b1;
        addr_d = addr_q + ADDR_W'(1);
        if (eol) begin
          line_end = 1'b1;
        end else if (act_end) begin
          state_d = HBLANK;
        end
      end
      HBLANK: begin
        adv = 1'b1;
        if (eol) line_end = 1'b1;
      end
      VBLANK: begin
        adv = 1'b1;
        if (eof) boundary = 1'b1;
      end
    endcase

    if (line_end) begin
      if (eof) begin
        boundary = 1'b1;
      end else if (last_line) begin
        state_d = VBLANK;
      end else begin
        state_d = ACTIVE;
      end
    end

    // Frame boundary (and IDLE) re-qualify and re-latch geometry with no gap cycle.
    if (boundary) begin
      if (start_ok) begin
        state_d = ACTIVE;
        load    = 1'b1;
        addr_d  = '0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      ren_q    <= 1'b0;
      valid_q  <= 1'b0;
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
      fstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      ren_q    <= (state_d == ACTIVE);
      valid_q  <= (state_q == ACTIVE);
      hblank_q <= (state_q == HBLANK) || ((state_q == VBLANK) && hb_pos);
      vblank_q <= (state_q == VBLANK);
      fstart_q <= (state_q == ACTIVE) && first;
    end
  end

  assign bus.FrameREn   = ren_q;
  assign bus.FrameRAddr = addr_q;
  // Read data arrives with the registered flags, so it is only gated here.
  assign bus.PixelOut   = valid_q ? bus.FrameRData : '0;
  assign bus.PixelValid = valid_q;
  assign bus.HBlank     = hblank_q;
  assign bus.VBlank     = vblank_q;
  assign bus.FrameStart = fstart_q;

`ifdef FRAME_SCANOUT_CHECKSUM_EN
  logic [15:0] sum_q;
  logic [15:0] sum_d;
  logic [15:0] csum_q;
  logic        csv_q;
  logic        lastpix_q;

  assign sum_d = (fstart_q ? 16'd0 : sum_q) + 16'(bus.PixelOut);

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q     <= '0;
      csum_q    <= '0;
      csv_q     <= 1'b0;
      lastpix_q <= 1'b0;
    end else begin
      lastpix_q <= (state_q == ACTIVE) && act_end && last_line;
      csv_q     <= lastpix_q;
      if (valid_q)   sum_q  <= sum_d;
      if (lastpix_q) csum_q <= sum_d;
    end
  end

  assign FrameChecksum = csum_q;
  assign ChecksumValid = csv_q;
`endif

endmodule
